// File: rtl/step_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_counter_pkg
// Description : Shared mode encodings and bound-clamp helper for the
//               step_updown_counter family.
// Revision    : 1.0 - initial release
// ============================================================================
package step_counter_pkg;

  // Boundary behaviour selector; the reserved code behaves like saturate.
  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Clamp helper works on a fixed 32-bit container; callers zero-extend
  // their N-bit operands (N <= 32) and truncate the result.
  localparam int unsigned CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp_range(
    input logic [CLAMP_W-1:0] val,
    input logic [CLAMP_W-1:0] lo,
    input logic [CLAMP_W-1:0] hi
  );
    logic [CLAMP_W-1:0] res;
    res = val;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : step_next_calc
// Description : Combinational next-value calculator. Forms the stepped
//               candidate in N+1 bits and flags overflow past Hi (up) or
//               underflow past Lo (down). Out-of-range starting values are
//               pulled back toward the bounds.
// Revision    : 1.0 - initial release
// ============================================================================
module step_next_calc
  import step_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] step_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  input  logic         up_i,
  output logic [N-1:0] cand_o,
  output logic         ovf_o,
  output logic         unf_o
);

  logic [N:0] w_q;
  logic [N:0] w_step;
  logic [N:0] w_lo;
  logic [N:0] w_hi;
  logic [N:0] w_sum;
  logic [N:0] w_diff;
  logic [N:0] w_room;

  // Candidate and event flags; a zero step never moves Q or raises an event.
  always_comb begin
    w_q    = {1'b0, q_i};
    w_step = {1'b0, step_i};
    w_lo   = {1'b0, lo_i};
    w_hi   = {1'b0, hi_i};
    w_sum  = w_q + w_step;
    w_diff = w_q - w_step;
    w_room = w_q - w_lo;
    cand_o = q_i;
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    if (step_i != '0) begin
      if (up_i) begin
        if (w_sum > w_hi) begin
          ovf_o = 1'b1;
        end else if (w_sum < w_lo) begin
          cand_o = lo_i;
        end else begin
          cand_o = w_sum[N-1:0];
        end
      end else begin
        // Starting below Lo is itself an underflow; w_room is only
        // meaningful once Q >= Lo.
        if ((w_q < w_lo) || (w_step > w_room)) begin
          unf_o = 1'b1;
        end else if (w_diff > w_hi) begin
          cand_o = hi_i;
        end else begin
          cand_o = w_diff[N-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/step_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : step_updown_counter
// Description : Up/down counter with runtime step and bounds [Lo, Hi],
//               wrap / saturate / bounce boundary modes, synchronous clamped
//               load and a registered terminal-count pulse.
//               Optional macro STEP_COUNTER_EVENT_COUNT_EN adds EvtCnt, a
//               modulo-2^CW count of Tc pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module step_updown_counter
  import step_counter_pkg::*;
#(
  parameter int             N         = 4,
  parameter logic [N-1:0]   RESET_VAL = N'(1),
  parameter int             CW        = 8
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic          Enable,
  input  logic          Up,
  input  logic [1:0]    Mode,
  input  logic          Load,
  input  logic [N-1:0]  LoadVal,
  input  logic [N-1:0]  StepSize,
  input  logic [N-1:0]  Lo,
  input  logic [N-1:0]  Hi,
  output logic [N-1:0]  Q,
  output logic          DirUp,
  output logic          Tc,
`ifdef STEP_COUNTER_EVENT_COUNT_EN
  output logic [CW-1:0] EvtCnt,
`endif
  output logic          AtLo,
  output logic          AtHi,
  output logic          CfgErr
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic         dir_q;
  logic         dir_d;
  logic         tc_q;
  logic         tc_d;

  logic         w_dir_eff;
  logic         w_bounce;
  logic [N-1:0] w_cand;
  logic         w_ovf;
  logic         w_unf;
  logic         w_evt;
  logic [N-1:0] w_load_val;

  assign CfgErr     = (Lo > Hi);
  assign AtLo       = (q_q == Lo);
  assign AtHi       = (q_q == Hi);
  assign Q          = q_q;
  assign DirUp      = dir_q;
  assign Tc         = tc_q;

  assign w_bounce   = (Mode == MODE_BOUNCE);
  assign w_dir_eff  = w_bounce ? dir_q : Up;
  assign w_evt      = w_dir_eff ? w_ovf : w_unf;
  assign w_load_val = N'(clamp_range(32'(LoadVal), 32'(Lo), 32'(Hi)));

  step_next_calc #(
    .N (N)
  ) u_next (
    .q_i    (q_q),
    .step_i (StepSize),
    .lo_i   (Lo),
    .hi_i   (Hi),
    .up_i   (w_dir_eff),
    .cand_o (w_cand),
    .ovf_o  (w_ovf),
    .unf_o  (w_unf)
  );

  // Next-state selection: CfgErr freezes, Load beats Enable, otherwise hold.
  always_comb begin
    q_d   = q_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (CfgErr) begin
      q_d = q_q;
    end else if (Load) begin
      q_d   = w_load_val;
      dir_d = Up;
    end else if (Enable) begin
      if (!w_bounce) begin
        dir_d = Up;
      end
      if (w_evt) begin
        tc_d = 1'b1;
        case (mode_e'(Mode))
          MODE_WRAP: q_d = w_dir_eff ? Lo : Hi;
          MODE_BOUNCE: begin
            q_d   = w_dir_eff ? Hi : Lo;
            dir_d = ~dir_q;
          end
          default: q_d = w_dir_eff ? Hi : Lo;
        endcase
      end else begin
        q_d = w_cand;
      end
    end
  end

  // Counter state registers with asynchronous reset.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      q_q   <= RESET_VAL;
      dir_q <= 1'b1;
      tc_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end

`ifdef STEP_COUNTER_EVENT_COUNT_EN
  logic [CW-1:0] evt_cnt_q;
  logic [CW-1:0] evt_cnt_d;

  assign EvtCnt = evt_cnt_q;

  // Event count advances together with each Tc pulse; an accepted Load clears it.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (!CfgErr && Load) begin
      evt_cnt_d = '0;
    end else if (tc_d) begin
      evt_cnt_d = evt_cnt_q + CW'(1);
    end
  end

  // Event counter register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_updown_counter
// Description : Directed self-checking bench for step_updown_counter.
//               Exercises EvtCnt when STEP_COUNTER_EVENT_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_updown_counter;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          Clk;
  logic          nReset;
  logic          Enable;
  logic          Up;
  logic [1:0]    Mode;
  logic          Load;
  logic [N-1:0]  LoadVal;
  logic [N-1:0]  StepSize;
  logic [N-1:0]  Lo;
  logic [N-1:0]  Hi;
  logic [N-1:0]  Q;
  logic          DirUp;
  logic          Tc;
  logic          AtLo;
  logic          AtHi;
  logic          CfgErr;
`ifdef STEP_COUNTER_EVENT_COUNT_EN
  logic [CW-1:0] EvtCnt;
`endif

  int checks = 0;
  int errors = 0;

  step_updown_counter #(
    .N         (N),
    .RESET_VAL (4'd1),
    .CW        (CW)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .Enable   (Enable),
    .Up       (Up),
    .Mode     (Mode),
    .Load     (Load),
    .LoadVal  (LoadVal),
    .StepSize (StepSize),
    .Lo       (Lo),
    .Hi       (Hi),
    .Q        (Q),
    .DirUp    (DirUp),
    .Tc       (Tc),
`ifdef STEP_COUNTER_EVENT_COUNT_EN
    .EvtCnt   (EvtCnt),
`endif
    .AtLo     (AtLo),
    .AtHi     (AtHi),
    .CfgErr   (CfgErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] bq [7];
    logic         btc[7];
    logic         bdir[7];
    bq   = '{4'd4, 4'd8, 4'd9, 4'd5, 4'd1, 4'd0, 4'd4};
    btc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bdir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    nReset = 1'b0; Enable = 1'b0; Up = 1'b1; Mode = 2'd0; Load = 1'b0;
    LoadVal = '0; StepSize = 4'd2; Lo = 4'd1; Hi = 4'd13;
    #12;
    check("rst_q",   Q, 1);
    check("rst_dir", DirUp, 1);
    check("rst_tc",  Tc, 0);
    check("rst_atlo", AtLo, 1);
    @(negedge Clk);
    nReset = 1'b1;

    // Odd-only wrap counting 1,3,..,13 then back to 1 with a single Tc.
    Enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("wrap_q",  Q, 1 + 2 * k);
      check("wrap_tc", Tc, 0);
    end
    tick();
    check("wrap_evt_q",  Q, 1);
    check("wrap_evt_tc", Tc, 1);
    tick();
    check("wrap_after_q",  Q, 3);
    check("wrap_after_tc", Tc, 0);

    // Asynchronous reset mid-count.
    #1 nReset = 1'b0;
    #1;
    check("mid_rst_q", Q, 1);
    Enable = 1'b0;
    nReset = 1'b1;

    // Saturate downward: lands on Lo, then keeps pulsing while parked.
    Mode = 2'd1; Up = 1'b0; LoadVal = 4'd3; Load = 1'b1;
    tick();
    check("sat_load_q",   Q, 3);
    check("sat_load_dir", DirUp, 0);
    Load = 1'b0; Enable = 1'b1;
    tick();
    check("sat_q1",  Q, 1);
    check("sat_tc1", Tc, 0);
    tick();
    check("sat_q2",  Q, 1);
    check("sat_tc2", Tc, 1);
    tick();
    check("sat_q3",  Q, 1);
    check("sat_tc3", Tc, 1);
    check("sat_atlo", AtLo, 1);
    Up = 1'b1;
    tick();
    check("sat_up_q",  Q, 3);
    check("sat_up_tc", Tc, 0);
    check("sat_up_dir", DirUp, 1);

    // Bounce between 0 and 9 with step 4; Up is ignored once loaded.
    Enable = 1'b0; Lo = 4'd0; Hi = 4'd9; StepSize = 4'd4; Mode = 2'd2;
    LoadVal = 4'd0; Up = 1'b1; Load = 1'b1;
    tick();
    check("bnc_load_q", Q, 0);
    Load = 1'b0; Up = 1'b0; Enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("bnc_q",   Q, bq[k]);
      check("bnc_tc",  Tc, btc[k]);
      check("bnc_dir", DirUp, bdir[k]);
    end

    // Load beats Enable and clamps into [Lo, Hi]; zero step holds.
    Mode = 2'd0; Lo = 4'd1; Hi = 4'd13; Up = 1'b1;
    LoadVal = 4'd15; Load = 1'b1; Enable = 1'b1;
    tick();
    check("ld_clamp_q",  Q, 13);
    check("ld_clamp_tc", Tc, 0);
    check("ld_athi",     AtHi, 1);
    Load = 1'b0; StepSize = 4'd0;
    tick();
    check("step0_q",  Q, 13);
    check("step0_tc", Tc, 0);

    // Inverted bounds freeze the counter against both Enable and Load.
    Lo = 4'd10; Hi = 4'd5; StepSize = 4'd2;
    #1;
    check("cfgerr_on", CfgErr, 1);
    tick();
    check("cfg_en_q",  Q, 13);
    check("cfg_en_tc", Tc, 0);
    LoadVal = 4'd7; Load = 1'b1;
    tick();
    check("cfg_ld_q", Q, 13);
    Load = 1'b0; Lo = 4'd0;
    #1;
    check("cfgerr_off", CfgErr, 0);
    // Q=13 now sits above Hi=5: the next up step is an overflow and wraps to Lo.
    tick();
    check("resume_q",  Q, 0);
    check("resume_tc", Tc, 1);
    tick();
    check("resume2_q",  Q, 2);
    check("resume2_tc", Tc, 0);

`ifdef STEP_COUNTER_EVENT_COUNT_EN
    // Lo=Hi=0 with step 1 makes every enabled cycle a wrap event.
    Enable = 1'b0; Lo = 4'd0; Hi = 4'd0; StepSize = 4'd1;
    LoadVal = 4'd0; Load = 1'b1;
    tick();
    check("evt_clr0", EvtCnt, 0);
    Load = 1'b0; Enable = 1'b1;
    repeat (300) tick();
    check("evt_300", EvtCnt, 44);
    check("evt_tc",  Tc, 1);
    Load = 1'b1;
    tick();
    check("evt_ld_clr", EvtCnt, 0);
    Load = 1'b0; Enable = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
